// File: rtl/chess_pkg.sv
// Shared definitions for the board-level move path: word geometry,
// move flag layout and the collector state encoding.
package chess_pkg;

    localparam int MOVE_W    = 160;
    localparam int COL_COUNT = 8;
    localparam int FLAG_W    = 7;
    localparam int SQ_W      = 6;

    // Flag field of a move word, MSB first.
    typedef struct packed {
        logic invalid;
        logic promote;
        logic pawn_move;
        logic pawn_2sq;
        logic en_passant;
        logic castle;
        logic capture;
    } move_flags_t;

    typedef logic [FLAG_W-1:0] flag_bits_t;

    // Flags plus from/to squares as carried at the top of a move word.
    typedef struct packed {
        move_flags_t     flags;
        logic [SQ_W-1:0] from_sq;
        logic [SQ_W-1:0] to_sq;
    } move_head_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        FLUSH,
        DONE
    } coll_state_t;

endpackage

// File: rtl/board_move_collector_if.sv
// Valid/ready move stream from the collector to the search/eval stage.
interface board_move_collector_if
    import chess_pkg::*;
#(
    parameter int WORDW = MOVE_W
);
    logic [WORDW-1:0] moveOut;
    logic             moveValid;
    logic             moveReady;

    modport master (output moveOut, output moveValid, input moveReady);
    modport slave  (input moveOut, input moveValid, output moveReady);
endinterface

// File: rtl/board_move_collector_skid.sv
// Two-entry valid/ready buffer between the column FIFO read port and the
// move stream. Occupancy is exported so the reader can count credits.
module move_skid_buf
    import chess_pkg::*;
#(
    parameter int WORDW = MOVE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WORDW-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WORDW-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [1:0]       occ;
    logic [WORDW-1:0] head;
    logic [WORDW-1:0] tail;
    logic             pop;
    logic             push;

    assign push      = in_valid;
    assign pop       = (occ != 2'd0) && out_ready;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign occupancy = occ;

    // Entry count; the reader never pushes into a full buffer without a pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Head entry drives the stream, so it is cleared to give a zero word out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
        end else if ((occ == 2'd0 && push) || (occ == 2'd1 && push && pop)) begin
            head <= in_data;
        end else if (occ == 2'd2 && pop) begin
            head <= tail;
        end
    end

    // Second entry only holds data behind a stalled head.
    always_ff @(posedge clk) begin
        if ((occ == 2'd1 && push && !pop) || (occ == 2'd2 && push && pop)) begin
            tail <= in_data;
        end
    end

endmodule

// File: rtl/board_move_collector.sv
// Round-robin reader of the per-column move FIFOs. Drains each finished
// column in turn onto one move stream, with a watchdog that ends the pass
// early if the columns take too long.
module board_move_collector
    import chess_pkg::*;
#(
    parameter int          NCOL    = COL_COUNT,
    parameter int          WORDW   = MOVE_W,
    parameter logic [11:0] WDT_VAL = 12'd200,
    parameter int          CNTW    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NCOL-1:0]         colDone,
    input  logic [NCOL-1:0]         colEmpty,
    input  logic [NCOL*WORDW-1:0]   colFifoOut,
    output logic [NCOL-1:0]         colRden,
    board_move_collector_if.master  move_if,
    output logic [CNTW-1:0]         wordCount,
    output logic                    timeout,
    output logic                    done
);

    localparam int PTRW = (NCOL > 1) ? $clog2(NCOL) : 1;

    coll_state_t       state;
    logic [NCOL-1:0]   drained;
    logic [PTRW-1:0]   ptr;
    logic              rd_pending;
    logic [11:0]       wdt;

    logic [NCOL-1:0]   eligible;
    logic              scan_found;
    logic [PTRW-1:0]   scan_idx;
    logic [PTRW-1:0]   ptr_next;
    logic              wdt_zero;
    logic [1:0]        buf_occ;
    logic              buf_pop;
    logic [2:0]        pending_load;
    logic              credit_ok;
    logic              rd_issue;
    logic [WORDW-1:0]  sel_word;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    assign eligible     = colDone & ~drained;
    assign wdt_zero     = (wdt == 12'd0);
    assign ptr_next     = (ptr == PTRW'(NCOL - 1)) ? '0 : ptr + PTRW'(1);
    assign buf_pop      = move_if.moveValid && move_if.moveReady;
    assign sel_word     = colFifoOut[int'(ptr)*WORDW +: WORDW];

    // Words held plus words on their way; a word leaving this cycle frees
    // its slot in time for a read issued now, which keeps one word per cycle.
    assign pending_load = {1'b0, buf_occ} + {2'b00, rd_pending};
    assign credit_ok    = pending_load < (3'd2 + {2'b00, buf_pop});

    assign rd_issue     = (state == DRAIN) && !colEmpty[ptr] && credit_ok && !wdt_zero;

    // First eligible column at or after ptr, wrapping around the board.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = ptr;
        for (int k = 0; k < NCOL; k++) begin
            if (!scan_found && eligible[(int'(ptr) + k) % NCOL]) begin
                scan_found = 1'b1;
                scan_idx   = PTRW'((int'(ptr) + k) % NCOL);
            end
        end
    end

    // Read strobe goes only to the column being drained, and only when it has data.
    always_comb begin
        colRden = '0;
        if (rd_issue) begin
            colRden[ptr] = 1'b1;
        end
    end

    move_skid_buf #(
        .WORDW (WORDW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_pending),
        .in_data   (sel_word),
        .out_ready (move_if.moveReady),
        .out_valid (move_if.moveValid),
        .out_data  (move_if.moveOut),
        .occupancy (buf_occ)
    );

    // Pass sequencing, watchdog, forwarded-word count and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            drained    <= '0;
            ptr        <= '0;
            rd_pending <= 1'b0;
            wdt        <= 12'd0;
            wordCount  <= '0;
            timeout    <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_pending <= rd_issue;
            if (!wdt_zero && (state == SCAN || state == DRAIN)) begin
                wdt <= wdt - 12'd1;
            end
            if (buf_pop) begin
                wordCount <= sat_inc(wordCount);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SCAN;
                        drained   <= '0;
                        wordCount <= '0;
                        timeout   <= 1'b0;
                        done      <= 1'b0;
                        wdt       <= WDT_VAL;
                    end
                end
                SCAN: begin
                    if (&drained) begin
                        state <= FLUSH;
                    end else if (wdt_zero) begin
                        state   <= FLUSH;
                        timeout <= 1'b1;
                    end else if (scan_found) begin
                        ptr   <= scan_idx;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave only once the last read has landed in the buffer.
                    if (!rd_pending && wdt_zero) begin
                        state   <= FLUSH;
                        timeout <= 1'b1;
                    end else if (!rd_pending && colEmpty[ptr]) begin
                        drained[ptr] <= 1'b1;
                        ptr          <= ptr_next;
                        state        <= SCAN;
                    end
                end
                FLUSH: begin
                    if (buf_occ == 2'd0 && !rd_pending) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_move_collector.sv
// Directed bench for board_move_collector: column FIFO model, cycle monitor
// for read-strobe rules, stream hold and credit limit, and word scoreboard.
`timescale 1ns/1ps
module tb_board_move_collector;

    localparam int          NCOL  = 8;
    localparam int          WORDW = 160;
    localparam int          CNTW  = 10;
    localparam logic [11:0] WDT   = 12'd50;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [NCOL-1:0]       colDone;
    logic [NCOL-1:0]       colEmpty;
    logic [NCOL*WORDW-1:0] colFifoOut;
    logic [NCOL-1:0]       colRden;
    logic [CNTW-1:0]       wordCount;
    logic                  timeout;
    logic                  done;

    board_move_collector_if mif ();

    board_move_collector #(
        .NCOL    (NCOL),
        .WORDW   (WORDW),
        .WDT_VAL (WDT),
        .CNTW    (CNTW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .colDone    (colDone),
        .colEmpty   (colEmpty),
        .colFifoOut (colFifoOut),
        .colRden    (colRden),
        .move_if    (mif),
        .wordCount  (wordCount),
        .timeout    (timeout),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Column FIFO model: fill[] words per column, read index advanced on rden,
    // data appears the cycle after the strobe.
    int   fill   [NCOL];
    int   rd_idx [NCOL];
    logic fifo_clr;

    function automatic logic [WORDW-1:0] word_of(input int col, input int idx);
        return {32'(col), 32'(idx), 32'hC0DE_0000 ^ 32'(col * 1000 + idx),
                32'(idx * 7 + col), 32'hFACE_0000 + 32'(idx)};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NCOL; i++) begin
            if (fifo_clr) begin
                rd_idx[i] <= 0;
            end else if (colRden[i]) begin
                colFifoOut[i*WORDW +: WORDW] <= word_of(i, rd_idx[i]);
                rd_idx[i] <= rd_idx[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCOL; i++) begin
            colEmpty[i] = (rd_idx[i] >= fill[i]);
        end
    end

    int               checks = 0;
    int               failures = 0;
    int               rden_viol = 0;
    int               hold_viol = 0;
    int               credit_viol = 0;
    int               reads = 0;
    int               accepted = 0;
    logic [WORDW-1:0] got [$];
    bit               ready_toggle = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WORDW-1:0] prev_out = '0;

    task automatic check_val(input string tag, input logic [WORDW-1:0] act, input logic [WORDW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: observe mid-cycle, then drive next-cycle ready after the edge.
    task automatic tick();
        @(negedge clk);
        if (colRden != '0 && !$onehot(colRden)) rden_viol++;
        if ((colRden & colEmpty) != '0) rden_viol++;
        if (colRden != '0) reads++;
        if (prev_stall && (!mif.moveValid || mif.moveOut !== prev_out)) hold_viol++;
        if (mif.moveValid && mif.moveReady) begin
            got.push_back(mif.moveOut);
            accepted++;
        end
        if (reads - accepted > 2) credit_viol++;
        prev_stall = reset && mif.moveValid && !mif.moveReady;
        prev_out   = mif.moveOut;
        @(posedge clk);
        #1;
        if (ready_toggle) mif.moveReady = ~mif.moveReady;
        else              mif.moveReady = 1'b1;
    endtask

    task automatic reload();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        got.delete();
        reads    = 0;
        accepted = 0;
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, done, 1);
    endtask

    task automatic check_words(input string tag, input int col, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            check_val(tag, (base + k < got.size()) ? got[base + k] : '0, word_of(col, k));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        colDone = '0;
        fifo_clr = 1'b0;
        mif.moveReady = 1'b1;
        for (int i = 0; i < NCOL; i++) fill[i] = 0;
        tick();
        tick();
        #1;
        check_val("rst_rden", colRden, 0);
        check_val("rst_valid", mif.moveValid, 0);
        check_val("rst_moveOut", mif.moveOut, 0);
        check_val("rst_wordCount", wordCount, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_done", done, 0);
        reset = 1'b1;

        // Columns 0,3,7 hold 2,5,1 words, every column done, ready always high.
        fill[0] = 2; fill[3] = 5; fill[7] = 1;
        reload();
        colDone = '1;
        start_pass();
        wait_done("t1_done", 200);
        check_val("t1_count", got.size(), 8);
        check_words("t1_col0", 0, 2, 0);
        check_words("t1_col3", 3, 5, 2);
        check_words("t1_col7", 7, 1, 7);
        check_val("t1_wordCount", wordCount, 8);
        check_val("t1_timeout", timeout, 0);
        check_val("t1_valid_after", mif.moveValid, 0);

        // Same load with ready toggling every cycle.
        reload();
        ready_toggle = 1'b1;
        start_pass();
        wait_done("t2_done", 300);
        ready_toggle = 1'b0;
        check_val("t2_count", got.size(), 8);
        check_words("t2_col0", 0, 2, 0);
        check_words("t2_col3", 3, 5, 2);
        check_words("t2_col7", 7, 1, 7);
        check_val("t2_wordCount", wordCount, 8);
        check_val("t2_timeout", timeout, 0);
        check_val("t2_hold_stable", hold_viol, 0);
        check_val("t2_outstanding", credit_viol, 0);

        // Only column 5 reports done and its FIFO is empty: nothing is read,
        // and since the other columns never finish the watchdog ends the pass.
        for (int i = 0; i < NCOL; i++) fill[i] = 0;
        reload();
        colDone = 8'h20;
        start_pass();
        wait_done("t3_done", 300);
        check_val("t3_count", got.size(), 0);
        check_val("t3_reads", reads, 0);
        check_val("t3_wordCount", wordCount, 0);
        check_val("t3_timeout", timeout, 1);

        // Column 2 holds 300 words; the 50-cycle watchdog cuts the pass short.
        fill[2] = 300;
        reload();
        colDone = 8'h04;
        start_pass();
        wait_done("t4_done", 400);
        check_val("t4_timeout", timeout, 1);
        check_val("t4_read_bound", (reads > 0) && (reads <= int'(WDT)), 1);
        check_val("t4_fifo_left", rd_idx[2], reads);
        check_val("t4_not_empty", colEmpty[2], 0);
        check_val("t4_count", got.size(), reads);
        check_val("t4_wordCount", wordCount, CNTW'(reads));
        check_words("t4_words", 2, reads, 0);
        check_val("t4_outstanding", credit_viol, 0);

        // Reset in the middle of draining column 3, then a clean pass on column 1.
        fill[2] = 0;
        fill[3] = 20;
        reload();
        colDone = 8'h08;
        start_pass();
        for (int i = 0; i < 6; i++) tick();
        check_val("t5_mid_drain", reads > 0, 1);
        reset = 1'b0;
        tick();
        #1;
        check_val("t5_rden", colRden, 0);
        check_val("t5_valid", mif.moveValid, 0);
        check_val("t5_moveOut", mif.moveOut, 0);
        check_val("t5_wordCount", wordCount, 0);
        check_val("t5_done", done, 0);
        reset = 1'b1;
        fill[3] = 0;
        fill[1] = 3;
        reload();
        colDone = '1;
        start_pass();
        wait_done("t5_pass_done", 200);
        check_val("t5_count", got.size(), 3);
        check_words("t5_col1", 1, 3, 0);
        check_val("t5_pass_wordCount", wordCount, 3);
        check_val("t5_timeout", timeout, 0);
        check_val("t5_outstanding", credit_viol, 0);

        check_val("rden_rules", rden_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: bench did not reach its summary");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/board_move_collector.md
Name: board_move_collector

Overview:
- Board-level reader for the eight per-column move FIFOs filled by the column units.
- Scans columns 0..7 round-robin. Drains each finished column's FIFO through its rden/fifoEmpty pair and forwards every 160-bit move word on one valid/ready stream to the search/eval stage.
- Raises done once every column has been drained, or the watchdog expires.

Parameters:
- NCOL, 8, number of column FIFOs read
- WORDW, 160, width of one column FIFO word (opaque move bundle)
- WDT_VAL, 12'd200, watchdog cycles from start to forced finish
- CNTW, 10, width of the forwarded-word counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low (0 = reset)
- start  input  1  one-cycle pulse; arms a new collection pass
- colDone  input  NCOL  done flag of each column unit
- colEmpty  input  NCOL  fifoEmpty of each column FIFO
- colFifoOut  input  NCOL*WORDW  fifoOut of each column; column i occupies bits [i*WORDW +: WORDW]
- colRden  output  NCOL  rden to each column FIFO; one-hot or zero
- moveOut  output  WORDW  forwarded move word
- moveValid  output  1  moveOut valid
- moveReady  input  1  downstream accepts the word when valid&&ready
- wordCount  output  CNTW  words forwarded this pass; saturates at all-ones
- timeout  output  1  pass ended by the watchdog
- done  output  1  pass complete; held until start or reset

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; drained flags=0; ptr=0; skid buffer empty.
  - Outputs: colRden=0, moveValid=0, moveOut=0, wordCount=0, timeout=0, done=0.
- Column FIFO read latency: colFifoOut[i] is valid on the cycle after colRden[i] is asserted (normal, non-show-ahead mode).
- States:
  - IDLE: on start go to SCAN. Clear drained, wordCount, timeout, done; load the watchdog.
  - SCAN: a column is eligible when colDone[i] && !drained[i].
    - Search from ptr upward with wrap-around; go to DRAIN on the first eligible column, setting ptr to it.
    - If all drained flags are set, go to FLUSH.
  - DRAIN: assert colRden[ptr] when !colEmpty[ptr] && credits>0.
    - credits = 2 - (buffer occupancy + in-flight reads).
    - The word is captured into the skid buffer one cycle later.
    - When colEmpty[ptr]==1 with no read in flight: set drained[ptr], advance ptr (mod NCOL), return to SCAN.
  - FLUSH: wait for the skid buffer to empty, then go to DONE.
  - DONE: done=1, colRden=0. start re-enters SCAN with the same clearing as IDLE.
- colRden is never asserted while the addressed FIFO's empty flag is 1, and never asserted for more than one column in a cycle.
- Stream handshake:
  - moveOut and moveValid are registered and stable while valid && !ready.
  - Each accepted word increments wordCount by 1, saturating.
  - Word order: column order of draining, FIFO order within a column.
- Watchdog:
  - Counts down from WDT_VAL after start. When it reaches 0, stop issuing new rden (including in SCAN).
  - The in-flight read still lands. Go to FLUSH with timeout=1.
  - Undrained columns are left untouched.
- Simultaneous events:
  - start during SCAN/DRAIN/FLUSH is ignored.
  - A column whose colDone rises while another column is being drained is serviced on a later SCAN.
  - colDone[i]=1 with an empty FIFO marks column i drained with zero reads (two cycles: SCAN then DRAIN exit).
- reset mid-pass: abandons the pass in-flight; the dropped read word is lost, and all outputs return to reset values next cycle.
- Throughput: one word per cycle sustained while moveReady=1 and the FIFO is non-empty.

Decomposition:
- Shared package (chess_pkg):
  - move word width 160;
  - 7-bit flag field layout [invalid][promote][pawn move][pawn 2 sq][en passant][castle][capture] plus 6-bit from/to fields;
  - column count 8;
  - state encodings IDLE/SCAN/DRAIN/FLUSH/DONE.
- Sub-module move_skid_buf: 2-entry valid/ready buffer with occupancy output used for credit counting; everything else stays in the top.

Test Plan:
- Columns 0,3,7 preloaded with 2,5,1 words; all colDone=1; moveReady=1 → 8 words out in order col0,col3,col7; wordCount=8; done=1; timeout=0.
- Same load, moveReady toggles 1-0-1-0 → no word lost or duplicated; moveOut held stable while stalled; colRden never drives >2 outstanding.
- colDone[5] only, FIFO 5 empty → zero words; done after SCAN/DRAIN/FLUSH; wordCount=0.
- Column 2 has 300 words and WDT_VAL=50 → rden stops at the watchdog; done=1, timeout=1; remaining FIFO 2 words untouched.
- reset=0 asserted mid-DRAIN → next cycle colRden=0, moveValid=0, wordCount=0; a subsequent start runs a clean pass.
- Checker on every cycle: colRden one-hot or zero, and never asserted while the matching colEmpty=1.
